// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs drained round-robin onto one registered
// register-file write port. Define WB_ARB_PERF_EN to add conflict/full performance counters.
module wb_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_stall,
  input  logic [NUM_SRC-1:0]         i_valid,
  input  logic [NUM_SRC-1:0]         i_wren,
  input  logic [NUM_SRC-1:0]         i_rd_is_int,
  input  logic [NUM_SRC*5-1:0]       i_rd_addr,
  input  logic [NUM_SRC*32-1:0]      i_rd_data,
  output logic [NUM_SRC-1:0]         o_src_stall,
  output logic                       o_valid,
  output logic                       o_wren,
  output logic                       o_rd_is_int,
  output logic [4:0]                 o_rd_addr,
  output logic [31:0]                o_rd_data,
  output logic [$clog2(NUM_SRC)-1:0] o_src_id
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]                o_conflict_cnt,
  output logic [31:0]                o_full_cnt
`endif
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

  typedef struct packed {
    logic        is_int;
    logic        wren;
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t           mem_q    [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr_q [NUM_SRC];
  logic [CNT_W-1:0] cnt_q    [NUM_SRC];
  logic [SRC_W-1:0] rr_q;

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               gnt_valid;
  logic [SRC_W-1:0]   gnt_idx;
  int unsigned        cand;
  entry_t             head;

  // Full/empty come from registered counts only, so a full FIFO never takes a push
  // even when it is popped in the same cycle.
  always_comb begin
    full     = '0;
    nonempty = '0;
    push     = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      full[s]     = (cnt_q[s] == FULL_CNT);
      nonempty[s] = (cnt_q[s] != '0);
      push[s]     = i_valid[s] && !full[s];
    end
  end

  assign o_src_stall = full;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!gnt_valid && nonempty[SRC_W'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SRC_W'(cand);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (!i_stall && gnt_valid) pop[gnt_idx] = 1'b1;
  end

  assign head = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];

  // Storage needs no reset; validity is tracked entirely by the counts.
  always_ff @(posedge i_clk) begin
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (push[s]) begin
        mem_q[s][wr_ptr_q[s]] <= '{is_int: i_rd_is_int[s], wren: i_wren[s],
                                   addr: i_rd_addr[5*s +: 5], data: i_rd_data[32*s +: 32]};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        if (push[s]) wr_ptr_q[s] <= wr_ptr_q[s] + 1'b1;
        if (pop[s])  rd_ptr_q[s] <= rd_ptr_q[s] + 1'b1;
        case ({push[s], pop[s]})
          2'b10:   cnt_q[s] <= cnt_q[s] + 1'b1;
          2'b01:   cnt_q[s] <= cnt_q[s] - 1'b1;
          default: cnt_q[s] <= cnt_q[s];
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q        <= '0;
      o_valid     <= 1'b0;
      o_wren      <= 1'b0;
      o_rd_is_int <= 1'b0;
      o_rd_addr   <= '0;
      o_rd_data   <= '0;
      o_src_id    <= '0;
    end else if (!i_stall) begin
      if (gnt_valid) begin
        rr_q        <= (gnt_idx == LAST_SRC) ? '0 : gnt_idx + 1'b1;
        o_valid     <= 1'b1;
        // Integer x0 is hardwired zero; FP f0 is a real register.
        o_wren      <= head.wren & ~(head.is_int & (head.addr == 5'd0));
        o_rd_is_int <= head.is_int;
        o_rd_addr   <= head.addr;
        o_rd_data   <= head.data;
        o_src_id    <= gnt_idx;
      end else begin
        o_valid <= 1'b0;
        o_wren  <= 1'b0;
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  logic multi_pending;
  assign multi_pending = (nonempty & (nonempty - NUM_SRC'(1))) != '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_conflict_cnt <= '0;
      o_full_cnt     <= '0;
    end else begin
      if (!i_stall && multi_pending && (o_conflict_cnt != '1)) begin
        o_conflict_cnt <= o_conflict_cnt + 1'b1;
      end
      if ((|full) && (o_full_cnt != '1)) o_full_cnt <= o_full_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (NUM_SRC=4, FIFO_DEPTH=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wb_arbiter;

  localparam int NUM_SRC = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  stall;
  logic [NUM_SRC-1:0]    valid;
  logic [NUM_SRC-1:0]    wren;
  logic [NUM_SRC-1:0]    is_int;
  logic [NUM_SRC*5-1:0]  rd_addr;
  logic [NUM_SRC*32-1:0] rd_data;
  logic [NUM_SRC-1:0]    src_stall;
  logic                  o_valid;
  logic                  o_wren;
  logic                  o_rd_is_int;
  logic [4:0]            o_rd_addr;
  logic [31:0]           o_rd_data;
  logic [1:0]            o_src_id;
`ifdef WB_ARB_PERF_EN
  logic [31:0]           conflict_cnt;
  logic [31:0]           full_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // {valid, wren, is_int, addr, data, src_id}
  wire [41:0] obs = {o_valid, o_wren, o_rd_is_int, o_rd_addr, o_rd_data, o_src_id};

  always #5 clk = ~clk;

  wb_arbiter #(
    .NUM_SRC    (NUM_SRC),
    .FIFO_DEPTH (2)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stall        (stall),
    .i_valid        (valid),
    .i_wren         (wren),
    .i_rd_is_int    (is_int),
    .i_rd_addr      (rd_addr),
    .i_rd_data      (rd_data),
    .o_src_stall    (src_stall),
    .o_valid        (o_valid),
    .o_wren         (o_wren),
    .o_rd_is_int    (o_rd_is_int),
    .o_rd_addr      (o_rd_addr),
    .o_rd_data      (o_rd_data),
    .o_src_id       (o_src_id)
`ifdef WB_ARB_PERF_EN
    ,
    .o_conflict_cnt (conflict_cnt),
    .o_full_cnt     (full_cnt)
`endif
  );

  task automatic clear_inputs();
    stall   = 1'b0;
    valid   = '0;
    wren    = '0;
    is_int  = '0;
    rd_addr = '0;
    rd_data = '0;
  endtask

  task automatic set_src(input int s, input logic v, input logic we, input logic ii,
                         input logic [4:0] a, input logic [31:0] d);
    valid[s]          = v;
    wren[s]           = we;
    is_int[s]         = ii;
    rd_addr[5*s +: 5] = a;
    rd_data[32*s +: 32] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (obs !== 42'd0 || src_stall !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got obs=%h stall=%b, expected obs=0 stall=0000",
                 c, obs, src_stall);
      end
`ifdef WB_ARB_PERF_EN
      n_tests++;
      if (conflict_cnt !== 32'd0 || full_cnt !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_perf: got conflict=%0d full=%0d, expected 0 0",
                 conflict_cnt, full_cnt);
      end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_single_latency();
    do_reset();
    set_src(1, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    clear_inputs();
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got o_valid=%b, expected 0", o_valid);
    end
    @(negedge clk);
    n_tests++;
    if (obs !== {1'b1, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1}) begin
      n_fail++;
      $display("FAIL latency_emit: got %h, expected %h", obs,
               {1'b1, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1});
    end
    @(negedge clk);
    n_tests++;
    if (obs !== {1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1}) begin
      n_fail++;
      $display("FAIL latency_idle_hold: got %h, expected %h", obs,
               {1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1});
    end
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    for (int s = 0; s < NUM_SRC; s++) set_src(s, 1'b1, 1'b1, 1'b1, 5'(s + 1), 32'(s));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_tests++;
        if (o_valid !== 1'b0 || src_stall !== 4'b0000) begin
          n_fail++;
          $display("FAIL rr_first: got o_valid=%b stall=%b, expected 0 0000",
                   o_valid, src_stall);
        end
      end else begin
        e = (c - 1) % NUM_SRC;
        n_tests++;
        if (obs !== {1'b1, 1'b1, 1'b1, 5'(e + 1), 32'(e), 2'(e)}) begin
          n_fail++;
          $display("FAIL rr_order cyc %0d: got %h, expected %h", c, obs,
                   {1'b1, 1'b1, 1'b1, 5'(e + 1), 32'(e), 2'(e)});
        end
        n_tests++;
        if (src_stall !== (4'hF ^ (4'b0001 << e))) begin
          n_fail++;
          $display("FAIL rr_stall cyc %0d: got %b, expected %b", c, src_stall,
                   4'hF ^ (4'b0001 << e));
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    stall = 1'b1;
    set_src(2, 1'b1, 1'b1, 1'b1, 5'd10, 32'hAAAA_0001);
    @(negedge clk);
    n_tests++;
    if (src_stall !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_after_a: got stall=%b, expected 0000", src_stall);
    end
    set_src(2, 1'b1, 1'b1, 1'b1, 5'd11, 32'hBBBB_0002);
    @(negedge clk);
    n_tests++;
    if (src_stall !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_full: got stall=%b, expected 0100", src_stall);
    end
    set_src(2, 1'b1, 1'b1, 1'b1, 5'd12, 32'hCCCC_0003);
    @(negedge clk);
    n_tests++;
    if (src_stall !== 4'b0100 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold_c: got stall=%b o_valid=%b, expected 0100 0", src_stall, o_valid);
    end
    stall = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== {1'b1, 1'b1, 1'b1, 5'd10, 32'hAAAA_0001, 2'd2} || src_stall !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_emit_a: got %h stall=%b, expected %h 0000", obs, src_stall,
               {1'b1, 1'b1, 1'b1, 5'd10, 32'hAAAA_0001, 2'd2});
    end
    @(negedge clk);
    clear_inputs();
    n_tests++;
    if (obs !== {1'b1, 1'b1, 1'b1, 5'd11, 32'hBBBB_0002, 2'd2}) begin
      n_fail++;
      $display("FAIL bp_emit_b: got %h, expected %h", obs,
               {1'b1, 1'b1, 1'b1, 5'd11, 32'hBBBB_0002, 2'd2});
    end
    @(negedge clk);
    n_tests++;
    if (obs !== {1'b1, 1'b1, 1'b1, 5'd12, 32'hCCCC_0003, 2'd2}) begin
      n_fail++;
      $display("FAIL bp_emit_c: got %h, expected %h", obs,
               {1'b1, 1'b1, 1'b1, 5'd12, 32'hCCCC_0003, 2'd2});
    end
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drained: got o_valid=%b, expected 0", o_valid);
    end
  endtask

  task automatic test_x0_fp();
    do_reset();
    set_src(0, 1'b1, 1'b1, 1'b1, 5'd0, 32'h1111_1111);
    set_src(1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h2222_2222);
    set_src(2, 1'b1, 1'b0, 1'b1, 5'd7, 32'h3333_3333);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if (obs !== {1'b1, 1'b0, 1'b1, 5'd0, 32'h1111_1111, 2'd0}) begin
      n_fail++;
      $display("FAIL x0_suppress: got %h, expected %h", obs,
               {1'b1, 1'b0, 1'b1, 5'd0, 32'h1111_1111, 2'd0});
    end
    @(negedge clk);
    n_tests++;
    if (obs !== {1'b1, 1'b1, 1'b0, 5'd0, 32'h2222_2222, 2'd1}) begin
      n_fail++;
      $display("FAIL fp_f0_write: got %h, expected %h", obs,
               {1'b1, 1'b1, 1'b0, 5'd0, 32'h2222_2222, 2'd1});
    end
    @(negedge clk);
    n_tests++;
    if (obs !== {1'b1, 1'b0, 1'b1, 5'd7, 32'h3333_3333, 2'd2}) begin
      n_fail++;
      $display("FAIL no_wren_retire: got %h, expected %h", obs,
               {1'b1, 1'b0, 1'b1, 5'd7, 32'h3333_3333, 2'd2});
    end
    @(negedge clk);
    n_tests++;
    if (obs !== {1'b0, 1'b0, 1'b1, 5'd7, 32'h3333_3333, 2'd2}) begin
      n_fail++;
      $display("FAIL x0_idle_hold: got %h, expected %h", obs,
               {1'b0, 1'b0, 1'b1, 5'd7, 32'h3333_3333, 2'd2});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stall = 1'b1;
    set_src(0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_00A0);
    set_src(3, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_00A3);
    @(negedge clk);
    set_src(0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_00A1);
    set_src(3, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_00A4);
    @(negedge clk);
    valid = '0;
    n_tests++;
    if (src_stall !== 4'b1001) begin
      n_fail++;
      $display("FAIL mid_full: got stall=%b, expected 1001", src_stall);
    end
    @(negedge clk);
`ifdef WB_ARB_PERF_EN
    n_tests++;
    if (conflict_cnt !== 32'd0 || full_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_stalled: got conflict=%0d full=%0d, expected 0 1",
               conflict_cnt, full_cnt);
    end
`endif
    stall = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== {1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_00A0, 2'd0}) begin
      n_fail++;
      $display("FAIL mid_first_emit: got %h, expected %h", obs,
               {1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_00A0, 2'd0});
    end
`ifdef WB_ARB_PERF_EN
    n_tests++;
    if (conflict_cnt !== 32'd1 || full_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_counting: got conflict=%0d full=%0d, expected 1 2",
               conflict_cnt, full_cnt);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (obs !== 42'd0 || src_stall !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_state: got obs=%h stall=%b, expected 0 0000", obs, src_stall);
    end
`ifdef WB_ARB_PERF_EN
    n_tests++;
    if (conflict_cnt !== 32'd0 || full_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset: got conflict=%0d full=%0d, expected 0 0",
               conflict_cnt, full_cnt);
    end
`endif
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_discard cyc %0d: got o_valid=%b src=%0d, expected 0",
                 c, o_valid, o_src_id);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_latency();
    test_round_robin();
    test_backpressure();
    test_x0_fp();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side consumer of the per-unit result packages (rd_data, rd_addr, wren, valid, rd_is_int) produced by the execute units: ALU, BRU, LSU, MUL/DIV and FPU.
- Each source has a small FIFO. A round-robin arbiter drains the FIFOs one entry per cycle onto the single register-file write port.
- Back-pressure to each unit is driven through a per-source stall.
- Sits between the execute units and the integer/FP register files. The register-file write output is registered.

Parameters:
- NUM_SRC, 4, number of result sources; legal range 2..8.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, ≥2.

Ports:
- i_clk, input, 1, core clock; all state on rising edge.
- i_rst, input, 1, synchronous reset, active-high.
- i_stall, input, 1, register file cannot accept a write this cycle; no pop, output register holds.
- i_valid, input, NUM_SRC, per-source package valid.
- i_wren, input, NUM_SRC, per-source write enable.
- i_rd_is_int, input, NUM_SRC, 1 = integer destination, 0 = FP destination.
- i_rd_addr, input, NUM_SRC*5, per-source destination index; source s occupies [5s+4:5s].
- i_rd_data, input, NUM_SRC*32, per-source result; source s occupies [32s+31:32s].
- o_src_stall, output, NUM_SRC, source s FIFO full; unit must hold its package.
- o_valid, output, 1, registered write-port package valid.
- o_wren, output, 1, registered write strobe, qualified.
- o_rd_is_int, output, 1, registered destination file select.
- o_rd_addr, output, 5, registered destination index.
- o_rd_data, output, 32, registered write data.
- o_src_id, output, $clog2(NUM_SRC), registered index of the granted source (for scoreboard release).

Behaviour:
- Reset, synchronous on i_rst=1:
  - All FIFO counts and pointers = 0; round-robin pointer rr_ptr = 0.
  - o_valid = 0, o_wren = 0, o_rd_is_int = 0, o_rd_addr = 0, o_rd_data = 0, o_src_id = 0.
  - o_src_stall = 0, since it is derived from count.
  - Reset mid-operation discards all queued entries without emitting them.
- Push:
  - Source s pushes when i_valid[s]=1 and count[s] < FIFO_DEPTH.
  - A push is ignored while count[s] == FIFO_DEPTH. The producer holds, because o_src_stall[s]=1 that cycle.
  - o_src_stall[s] = (count[s] == FIFO_DEPTH), combinational from registered count.
  - A simultaneous pop on a full FIFO does not admit a push that cycle (no same-cycle pass-through).
- Arbitration, each cycle i_stall=0:
  - Grant g = first s with count[s] > 0, searching rr_ptr, rr_ptr+1, ..., wrapping mod NUM_SRC.
  - Grant is computed from registered counts only; an entry pushed this cycle is not eligible until next cycle.
  - On grant: pop FIFO g and set rr_ptr ← (g+1) mod NUM_SRC.
  - If all FIFOs are empty: no grant, rr_ptr unchanged.
- Simultaneous push and pop on the same non-full FIFO: count unchanged, both pointers advance. Pointers wrap at FIFO_DEPTH.
- Output register:
  - With a grant: o_valid ← 1, o_rd_addr/o_rd_data/o_rd_is_int ← head fields, o_src_id ← g.
  - o_wren ← head.wren & ~(head.rd_is_int & head.rd_addr == 0), so integer x0 is never written. FP f0 is writable.
  - No grant and i_stall=0: o_valid ← 0, o_wren ← 0; the other output fields hold.
  - i_stall=1: all outputs hold, no pops, rr_ptr holds. Pushes still occur subject to the full rule.
- Latency: a package presented at edge k (FIFO empty, source granted) appears on the outputs after edge k+1.
- Throughput: 1 package per cycle aggregate.
- Order: per-source order is preserved. No ordering guarantee across sources.
- A package with valid=1, wren=0 is still queued and emitted with o_valid=1, o_wren=0 for retirement.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- When defined:
  - Adds output o_conflict_cnt [31:0], reset 0.
  - Increments by 1 each cycle where i_stall=0 and more than one FIFO has count > 0.
  - Saturates at 32'hFFFF_FFFF.
  - Adds output o_full_cnt [31:0], reset 0. Increments each cycle where any o_src_stall bit is 1; same saturation.
- When undefined: neither port nor its counters exist; behaviour is otherwise identical.

Test Plan:
- Reset then idle:
  - i_rst=1 for 2 cycles, then i_valid=0.
  - Expect all outputs 0, rr_ptr=0, o_src_stall=4'b0000 indefinitely.
- Single-source latency:
  - Source 1 presents addr=5, data=32'hDEAD_BEEF, wren=1, is_int=1 at edge k.
  - Expect o_valid=1, o_wren=1, o_rd_addr=5, o_rd_data=32'hDEAD_BEEF, o_src_id=1 after edge k+1; o_valid=0 the following cycle.
- Round-robin fairness:
  - All 4 sources push one entry per cycle continuously, with data = source id.
  - Expect o_src_id sequence 0,1,2,3,0,1,… and no source starved.
- Full/back-pressure:
  - i_stall=1; source 2 pushes 3 packages A, B, C on consecutive cycles.
  - Expect A and B accepted and o_src_stall[2]=1 while C is held.
  - Then release i_stall; expect emission order A, B, C from source 2.
- x0 suppression and FP path:
  - Push is_int=1, addr=0, wren=1 → expect o_valid=1, o_wren=0.
  - Push is_int=0, addr=0, wren=1 → expect o_wren=1, o_rd_is_int=0.
- Reset mid-operation:
  - With 2 entries queued in sources 0 and 3, assert i_rst for 1 cycle.
  - Expect o_valid=0 and no queued entry ever emitted afterwards.
  - With WB_ARB_PERF_EN: counters read 0.
